// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

  localparam int NPORTS      = 2;
  localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed-priority one-hot grant: port 0 beats port 1 on a simultaneous request.
module sdram_arb_prio
  import sdram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[0])      grant[0] = 1'b1;
    else if (req[1]) grant[1] = 1'b1;
  end

endmodule

// File: rtl/sdram_arb.sv
// Two-port byte request front-end for the SDRAM controller's edge-triggered rd/we strobes.
// SDRAM_ARB_TIMEOUT_EN adds a WAIT watchdog that forces completion and sets a sticky err.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [7:0]    p0_din,
  output logic [7:0]    p0_dout,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [7:0]    p1_din,
  output logic [7:0]    p1_dout,
  output logic          p1_ack,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  output logic          sd_we,
  output logic          sd_rd,
  input  logic          sd_ready,
  input  logic [15:0]   sd_dout,
  output logic          busy,
  output logic          err
);

  state_t            state;
  logic              owner;
  logic              cur_we;
  logic [NPORTS-1:0] grant;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [7:0]        sel_din;
  logic [7:0]        rd_byte;
  logic [7:0]        rd_val;
  logic              tmo_hit;

  sdram_arb_prio u_prio (
    .req   ({p1_req, p0_req}),
    .grant (grant)
  );

  assign sel_we   = grant[1] ? p1_we   : p0_we;
  assign sel_addr = grant[1] ? p1_addr : p0_addr;
  assign sel_din  = grant[1] ? p1_din  : p0_din;
  assign rd_byte  = sd_addr[0] ? sd_dout[15:8] : sd_dout[7:0];
  assign rd_val   = tmo_hit ? 8'hFF : rd_byte;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT.
  assign tmo_hit = (state == WAIT) && !sd_ready && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == ISSUE)
        cnt <= '0;
      else if (state == SETTLE || state == WAIT)
        cnt <= cnt + CW'(1);
      if (tmo_hit)
        err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cur_we  <= 1'b0;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_we   <= 1'b0;
      sd_rd   <= 1'b0;
      p0_ack  <= 1'b0;
      p1_ack  <= 1'b0;
      p0_dout <= '0;
      p1_dout <= '0;
      busy    <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          // sd_ready gating also holds grants off until the controller finishes init.
          if (sd_ready && (|grant)) begin
            owner   <= grant[1];
            cur_we  <= sel_we;
            sd_addr <= sel_addr;
            sd_din  <= sel_din;
            sd_we   <= sel_we;
            sd_rd   <= !sel_we;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE:  state <= SETTLE;
        SETTLE: state <= WAIT;
        WAIT: begin
          if (sd_ready || tmo_hit) begin
            sd_we <= 1'b0;
            sd_rd <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
            if (owner) p1_ack <= 1'b1;
            else       p0_ack <= 1'b1;
            if (!cur_we) begin
              if (owner) p1_dout <= rd_val;
              else       p0_dout <= rd_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: behavioural controller, byte-level reference memory and completion-order model.
module tb_sdram_arb;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [7:0]    p0_din, p1_din, p0_dout, p1_dout;
  logic          p0_ack, p1_ack;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic          sd_we, sd_rd, busy, err;
  logic          sd_ready = 1'b0;
  logic [15:0]   sd_dout  = 16'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_arb #(.AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_dout(p0_dout), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_dout(p1_dout), .p1_ack(p1_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_ready(sd_ready), .sd_dout(sd_dout), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural controller (word memory) ----------------
  logic [15:0] wmem [logic [23:0]];
  int          ctl_lat   = 0;
  bit          ctl_boot  = 1'b1;
  bit          ctl_stuck = 1'b0;
  int          ctl_cnt   = 0;
  logic        prev_cmd  = 1'b0;
  logic [23:0] pend_w    = '0;

  function automatic logic [15:0] word_at(input logic [23:0] w);
    if (wmem.exists(w)) return wmem[w];
    return {w[7:0] ^ 8'hC3, w[7:0] ^ 8'h3C};
  endfunction

  always @(negedge clk) begin
    logic [23:0] w;
    logic [15:0] wd;
    w = sd_addr[AW-1:1];
    if (ctl_boot) begin
      sd_ready = 1'b0;
    end else if ((sd_rd || sd_we) && !prev_cmd) begin
      if (sd_we) begin
        wd = word_at(w);
        if (sd_addr[0]) wd[15:8] = sd_din;
        else            wd[7:0]  = sd_din;
        wmem[w] = wd;
      end
      if (ctl_lat == 0 && !ctl_stuck) begin
        sd_dout  = word_at(w);
        sd_ready = 1'b1;
      end else begin
        sd_ready = 1'b0;
        ctl_cnt  = ctl_lat;
        pend_w   = w;
      end
    end else if (!sd_ready && !ctl_stuck) begin
      if (ctl_cnt <= 1) begin
        sd_ready = 1'b1;
        sd_dout  = word_at(pend_w);
      end else begin
        ctl_cnt--;
      end
    end
    prev_cmd = sd_rd || sd_we;
  end

  // ---------------- protocol monitor ----------------
  int   overlap_cnt = 0, gap_cnt = 0, long_ack_cnt = 0;
  logic m_rd = 1'b0, m_we = 1'b0, m_a0 = 1'b0, m_a1 = 1'b0;
  always @(negedge clk) begin
    if (sd_rd && sd_we) overlap_cnt++;
    if ((sd_rd && !m_rd && m_we) || (sd_we && !m_we && m_rd)) gap_cnt++;
    if ((p0_ack && m_a0) || (p1_ack && m_a1) || (p0_ack && p1_ack)) long_ack_cnt++;
    m_rd = sd_rd; m_we = sd_we; m_a0 = p0_ack; m_a1 = p1_ack;
  end

  // ---------------- reference model: byte memory + service order ----------------
  logic [7:0] rmem [logic [AW-1:0]];

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
    logic [7:0] w;
    if (rmem.exists(a)) return rmem[a];
    w = a[8:1];
    return a[0] ? (w ^ 8'hC3) : (w ^ 8'h3C);
  endfunction

  task automatic run_txn(
    input  bit e0, input bit w0, input logic [AW-1:0] a0, input logic [7:0] d0,
    input  bit e1, input bit w1, input logic [AW-1:0] a1, input logic [7:0] d1,
    input  int lat,
    output int first, output logic [7:0] r0, output logic [7:0] r1);
    int         order[$];
    int         port, cyc;
    logic [7:0] h0, h1;
    h0 = p0_dout; h1 = p1_dout;
    r0 = 8'h00; r1 = 8'h00; first = -1;
    if (e0) order.push_back(0);
    if (e1) order.push_back(1);
    ctl_lat = lat;
    p0_req = e0; p0_we = w0; p0_addr = a0; p0_din = d0;
    p1_req = e1; p1_we = w1; p1_addr = a1; p1_din = d1;
    cyc = 0;
    while (order.size() > 0 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (p0_ack || p1_ack) begin
        port = p1_ack ? 1 : 0;
        if (first < 0) first = port;
        chk("ack_port_order", port, order[0]);
        void'(order.pop_front());
        if (port == 0) begin
          p0_req = 1'b0;
          if (w0) rmem[a0] = d0;
          else begin r0 = p0_dout; chk("p0_read_data", p0_dout, ref_byte(a0)); end
        end else begin
          p1_req = 1'b0;
          if (w1) rmem[a1] = d1;
          else begin r1 = p1_dout; chk("p1_read_data", p1_dout, ref_byte(a1)); end
        end
      end
    end
    chk("txn_completed", order.size(), 0);
    p0_req = 1'b0; p1_req = 1'b0;
    if (!e0 || w0) chk("p0_dout_hold", p0_dout, h0);
    if (!e1 || w1) chk("p1_dout_hold", p1_dout, h1);
  endtask

  typedef struct {
    bit e0; bit w0; logic [AW-1:0] a0; logic [7:0] d0;
    bit e1; bit w1; logic [AW-1:0] a1; logic [7:0] d1;
    int lat; int exp_first; logic [7:0] exp_r0; logic [7:0] exp_r1;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int         first, cyc, ack_cyc, ack_n, viol;
    logic [7:0] r0, r1;
    logic [4:0] rd_hist;

    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_din = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sd_we", sd_we, 0);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_addr", sd_addr, 0);
    chk("rst_sd_din", sd_din, 0);
    chk("rst_acks", {p0_ack, p1_ack}, 0);
    chk("rst_douts", {p0_dout, p1_dout}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    reset = 1'b0;

    // Boot: controller not ready, request must be held off.
    p1_req = 1; p1_we = 0; p1_addr = 25'h000002;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sd_rd || sd_we || busy) viol++;
    end
    chk("boot_no_strobe", viol, 0);
    ctl_boot = 1'b0;
    @(posedge clk); #1;
    chk("boot_rd_rise", sd_rd, 1);
    cyc = 0;
    while (!p1_ack && cyc < 20) begin @(posedge clk); #1; cyc++; end
    p1_req = 0;
    chk("boot_ack", p1_ack, 1);
    chk("boot_dout", p1_dout, ref_byte(25'h000002));
    @(posedge clk); #1;

    // Table-driven vectors.
    vecs.push_back('{1,1,25'h000101,8'hA5, 0,0,25'h0,8'h00,      3, 0, 8'h00, 8'h00});
    vecs.push_back('{0,0,25'h0,8'h00,      1,1,25'h000100,8'h5A, 2, 1, 8'h00, 8'h00});
    vecs.push_back('{0,0,25'h0,8'h00,      1,0,25'h000101,8'h00, 6, 1, 8'h00, 8'hA5});
    vecs.push_back('{0,0,25'h0,8'h00,      1,0,25'h000100,8'h00, 0, 1, 8'h00, 8'h5A});
    vecs.push_back('{1,1,25'h000000,8'h12, 1,0,25'h000000,8'h00, 4, 0, 8'h00, 8'h12});
    vecs.push_back('{1,1,25'h000011,8'h77, 1,0,25'h000010,8'h00, 0, 0, 8'h00, 8'h34});
    vecs.push_back('{1,0,25'h000101,8'h00, 0,0,25'h0,8'h00,      2, 0, 8'hA5, 8'h00});
    vecs.push_back('{1,0,25'h000000,8'h00, 1,0,25'h000011,8'h00, 1, 0, 8'h12, 8'h77});
    vecs.push_back('{0,0,25'h0,8'h00,      1,0,25'h0001FE,8'h00, 0, 1, 8'h00, 8'hC3});
    foreach (vecs[i]) begin
      run_txn(vecs[i].e0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
              vecs[i].e1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].lat, first, r0, r1);
      chk($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
      if (vecs[i].e0 && !vecs[i].w0) chk($sformatf("vec%0d_r0", i), r0, vecs[i].exp_r0);
      if (vecs[i].e1 && !vecs[i].w1) chk($sformatf("vec%0d_r1", i), r1, vecs[i].exp_r1);
    end

    // Read hit: exact 4-cycle latency, sd_rd high for 3 cycles.
    ctl_lat = 0;
    p1_req = 1; p1_we = 0; p1_addr = 25'h000100;
    ack_cyc = 0; ack_n = 0; rd_hist = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c <= 5) rd_hist[c-1] = sd_rd;
      if (p1_ack) begin ack_n++; ack_cyc = c; p1_req = 0; end
    end
    chk("hit_ack_cycle", ack_cyc, 4);
    chk("hit_ack_count", ack_n, 1);
    chk("hit_rd_shape", rd_hist, 5'b00111);
    chk("hit_dout", p1_dout, 8'h5A);

    // Reset while in WAIT.
    ctl_lat = 10;
    p1_req = 1; p1_we = 0; p1_addr = 25'h000101;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1; p1_req = 0;
    @(posedge clk); #1;
    chk("rst_wait_rd", sd_rd, 0);
    chk("rst_wait_busy", busy, 0);
    reset = 0;
    ack_n = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack || sd_rd || sd_we) ack_n++;
    end
    chk("rst_wait_quiet", ack_n, 0);
    run_txn(0, 0, '0, 8'h00, 1, 0, 25'h000101, 8'h00, 3, first, r0, r1);
    chk("post_rst_read", r1, 8'hA5);

    // Randomised traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      bit e0, e1;
      e0 = 1'($urandom_range(0, 1));
      e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(e0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 511)), 8'($urandom),
              e1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 511)), 8'($urandom),
              $urandom_range(0, 8), first, r0, r1);
      chk("rand_first", first, e0 ? 0 : 1);
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    ctl_stuck = 1'b1;
    p1_req = 1; p1_we = 0; p1_addr = 25'h000100;
    cyc = 0;
    while (!p1_ack && cyc < 40) begin @(posedge clk); #1; cyc++; end
    p1_req = 0;
    chk("tmo_ack", p1_ack, 1);
    chk("tmo_window", (cyc >= 16 && cyc <= 20), 1);
    chk("tmo_dout", p1_dout, 8'hFF);
    chk("tmo_err", err, 1);
    ctl_cnt = 0; ctl_stuck = 1'b0;
    repeat (2) @(posedge clk);
    run_txn(0, 0, '0, 8'h00, 1, 0, 25'h000100, 8'h00, 0, first, r0, r1);
    chk("tmo_err_sticky", err, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("tmo_err_cleared", err, 0);
`else
    chk("err_tied_low", err, 0);
`endif

    chk("no_rd_we_overlap", overlap_cnt, 0);
    chk("strobe_gap", gap_cnt, 0);
    chk("ack_single_pulse", long_ack_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
